// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core and its
// downstream display driver.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX_9 = 4'd9;
  localparam bcd_t DIGIT_MAX_5 = 4'd5;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 6;

  // Bit position of each digit's LSB inside the packed digits bus
  localparam int CS_ONES_LSB  = 0;
  localparam int CS_TENS_LSB  = 4;
  localparam int SEC_ONES_LSB = 8;
  localparam int SEC_TENS_LSB = 12;
  localparam int MIN_ONES_LSB = 16;
  localparam int MIN_TENS_LSB = 20;

  // Wrap value of digit idx, counting from cs_ones (idx 0) upward
  function automatic bcd_t digit_max(input int idx);
    bcd_t max_v;
    case (idx)
      3:       max_v = DIGIT_MAX_5;
      5:       max_v = DIGIT_MAX_5;
      default: max_v = DIGIT_MAX_9;
    endcase
    return max_v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with enable-in / carry-out for a ripple-enable chain.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX_9
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  bcd_t q_r;

  assign carry = en && (q_r == MAX);
  assign q     = q_r;

  // digit register: clear beats increment, wrap to zero after MAX
  always_ff @(posedge CLK) begin
    if (!rst) begin
      q_r <= 4'd0;
    end else if (clr) begin
      q_r <= 4'd0;
    end else if (en) begin
      q_r <= (q_r == MAX) ? 4'd0 : (q_r + 4'd1);
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// Start/stop/lap stopwatch core: centisecond prescaler, MM:SS.cc BCD count,
// lap snapshot and the four-state control FSM.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = 500000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        lap_clear,
  output logic [23:0] digits,
  output logic        running,
  output logic        lap_hold,
  output logic        rollover
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  sw_state_t         state_r;
  sw_state_t         next_state_s;
  logic              lap_take_s;
  logic              clear_s;
  logic              counting_s;
  logic              tick_s;
  logic [PW-1:0]     presc_r;
  logic [23:0]       count_s;
  logic [23:0]       snapshot_r;
  logic              running_r;
  logic              lap_hold_r;
  logic              rollover_r;
  logic [NUM_DIGITS:0] carry_s;

  // next state plus the one-cycle lap-capture and clear strobes
  always_comb begin
    next_state_s = state_r;
    lap_take_s   = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_stop) next_state_s = ST_RUN;
        else            next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (start_stop) begin
          next_state_s = ST_STOP;
        end else if (lap_clear) begin
          next_state_s = ST_LAP;
          lap_take_s   = 1'b1;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_LAP: begin
        if (start_stop)     next_state_s = ST_STOP;
        else if (lap_clear) next_state_s = ST_RUN;
        else                next_state_s = ST_LAP;
      end
      ST_STOP: begin
        if (start_stop) begin
          next_state_s = ST_RUN;
        end else if (lap_clear) begin
          next_state_s = ST_IDLE;
          clear_s      = 1'b1;
        end else begin
          next_state_s = ST_STOP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge CLK) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= next_state_s;
  end

  assign counting_s = (state_r == ST_RUN) || (state_r == ST_LAP);
  assign tick_s     = counting_s && (presc_r == PRESC_MAX);

  // prescaler: holds while stopped so a partial tick survives stop/resume
  always_ff @(posedge CLK) begin
    if (!rst) begin
      presc_r <= '0;
    end else if (clear_s || tick_s) begin
      presc_r <= '0;
    end else if (counting_s) begin
      presc_r <= presc_r + PW'(1);
    end else begin
      presc_r <= presc_r;
    end
  end

  assign carry_s[0] = tick_s;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit #(
      .MAX (digit_max(i))
    ) u_digit (
      .CLK   (CLK),
      .rst   (rst),
      .en    (carry_s[i]),
      .clr   (clear_s),
      .q     (count_s[i*DIGIT_W +: DIGIT_W]),
      .carry (carry_s[i+1])
    );
  end

  // lap snapshot takes the pre-edge count; a coincident tick still advances live
  always_ff @(posedge CLK) begin
    if (!rst) begin
      snapshot_r <= 24'd0;
    end else if (clear_s) begin
      snapshot_r <= 24'd0;
    end else if (lap_take_s) begin
      snapshot_r <= count_s;
    end else begin
      snapshot_r <= snapshot_r;
    end
  end

  // status flags registered from the next state so they align with it
  always_ff @(posedge CLK) begin
    if (!rst) begin
      running_r  <= 1'b0;
      lap_hold_r <= 1'b0;
      rollover_r <= 1'b0;
    end else begin
      running_r  <= (next_state_s == ST_RUN) || (next_state_s == ST_LAP);
      lap_hold_r <= (next_state_s == ST_LAP);
      rollover_r <= carry_s[NUM_DIGITS];
    end
  end

  assign digits   = lap_hold_r ? snapshot_r : count_s;
  assign running  = running_r;
  assign lap_hold = lap_hold_r;
  assign rollover = rollover_r;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer: CLK_DIV=4 instance for control/lap/reset,
// CLK_DIV=1 instance for the full 59:59.99 rollover.
module tb_stopwatch_timer;

  logic        CLK;
  logic        rst;
  logic        start_stop;
  logic        lap_clear;
  logic [23:0] digits;
  logic        running;
  logic        lap_hold;
  logic        rollover;

  logic        start_stop_b;
  logic        lap_clear_b;
  logic [23:0] digits_b;
  logic        running_b;
  logic        lap_hold_b;
  logic        rollover_b;

  int n_checks;
  int n_fails;

  stopwatch_timer #(.CLK_DIV(4)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .start_stop (start_stop),
    .lap_clear  (lap_clear),
    .digits     (digits),
    .running    (running),
    .lap_hold   (lap_hold),
    .rollover   (rollover)
  );

  stopwatch_timer #(.CLK_DIV(1)) dut_b (
    .CLK        (CLK),
    .rst        (rst),
    .start_stop (start_stop_b),
    .lap_clear  (lap_clear_b),
    .digits     (digits_b),
    .running    (running_b),
    .lap_hold   (lap_hold_b),
    .rollover   (rollover_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // drive a one-cycle pulse from a negedge; returns at the negedge after the sampling edge
  task automatic pulse_a(input logic ss, input logic lc);
    start_stop = ss;
    lap_clear  = lc;
    @(negedge CLK);
    start_stop = 1'b0;
    lap_clear  = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst          = 1'b0;
    start_stop   = 1'b0;
    lap_clear    = 1'b0;
    start_stop_b = 1'b0;
    lap_clear_b  = 1'b0;

    // reset and idle
    wait_cycles(2);
    check("rst_digits",   digits,   24'h000000);
    check("rst_running",  {23'd0, running},  24'd0);
    check("rst_lap_hold", {23'd0, lap_hold}, 24'd0);
    check("rst_rollover", {23'd0, rollover}, 24'd0);
    check("rst_b_digits", digits_b, 24'h000000);
    rst = 1'b1;
    pulse_a(1'b0, 1'b1);
    check("idle_lc_digits",  digits,  24'h000000);
    check("idle_lc_running", {23'd0, running}, 24'd0);
    wait_cycles(5);
    check("idle_hold_digits", digits, 24'h000000);

    // run: first increment 4 cycles after the start edge, 0x10 after 40
    pulse_a(1'b1, 1'b0);
    check("run_running", {23'd0, running}, 24'd1);
    check("run_edge0",   digits, 24'h000000);
    wait_cycles(3);
    check("run_edge3",   digits, 24'h000000);
    wait_cycles(1);
    check("run_edge4",   digits, 24'h000001);
    wait_cycles(36);
    check("run_edge40",  digits, 24'h000010);

    // stop freezes the count; prescaler holds 1
    pulse_a(1'b1, 1'b0);
    check("stop_running", {23'd0, running}, 24'd0);
    check("stop_digits",  digits, 24'h000010);
    wait_cycles(10);
    check("stop_frozen",  digits, 24'h000010);

    // simultaneous pulses in STOP: resume, lap_clear dropped, partial tick kept
    pulse_a(1'b1, 1'b1);
    check("prio_running",  {23'd0, running},  24'd1);
    check("prio_lap_hold", {23'd0, lap_hold}, 24'd0);
    check("prio_digits",   digits, 24'h000010);
    wait_cycles(2);
    check("resume_edge2",  digits, 24'h000010);
    wait_cycles(1);
    check("resume_edge3",  digits, 24'h000011);

    // stop then clear
    pulse_a(1'b1, 1'b0);
    check("stop2_digits",  digits, 24'h000011);
    check("stop2_running", {23'd0, running}, 24'd0);
    pulse_a(1'b0, 1'b1);
    check("clear_digits",  digits, 24'h000000);
    check("clear_running", {23'd0, running}, 24'd0);
    wait_cycles(8);
    check("clear_idle",    digits, 24'h000000);

    // lap freeze at 0x05, live count reaches 0x07 meanwhile
    pulse_a(1'b1, 1'b0);
    wait_cycles(20);
    check("lap_pre", digits, 24'h000005);
    pulse_a(1'b0, 1'b1);
    check("lap_hold_on",  {23'd0, lap_hold}, 24'd1);
    check("lap_running",  {23'd0, running},  24'd1);
    check("lap_digits0",  digits, 24'h000005);
    for (int i = 0; i < 8; i++) begin
      wait_cycles(1);
      check("lap_frozen", digits, 24'h000005);
    end
    pulse_a(1'b0, 1'b1);
    check("unlap_digits",   digits, 24'h000007);
    check("unlap_lap_hold", {23'd0, lap_hold}, 24'd0);
    check("unlap_running",  {23'd0, running},  24'd1);

    // reset mid-run at 0x123
    wait_cycles(462);
    check("pre_rst_digits", digits, 24'h000123);
    rst = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    check("mrst_digits",   digits, 24'h000000);
    check("mrst_running",  {23'd0, running},  24'd0);
    check("mrst_lap_hold", {23'd0, lap_hold}, 24'd0);
    check("mrst_rollover", {23'd0, rollover}, 24'd0);
    wait_cycles(12);
    check("mrst_idle",     digits, 24'h000000);
    pulse_a(1'b1, 1'b0);
    wait_cycles(3);
    check("restart_edge3", digits, 24'h000000);
    wait_cycles(1);
    check("restart_edge4", digits, 24'h000001);

    // LAP -> STOP shows live count, not the snapshot
    pulse_a(1'b0, 1'b1);
    check("lap2_digits", digits, 24'h000001);
    wait_cycles(4);
    check("lap2_frozen", digits, 24'h000001);
    pulse_a(1'b1, 1'b0);
    check("lapstop_digits",   digits, 24'h000002);
    check("lapstop_lap_hold", {23'd0, lap_hold}, 24'd0);
    check("lapstop_running",  {23'd0, running},  24'd0);

    // full rollover on the CLK_DIV=1 instance
    start_stop_b = 1'b1;
    @(negedge CLK);
    start_stop_b = 1'b0;
    check("b_running", {23'd0, running_b}, 24'd1);
    wait_cycles(6000);
    check("b_one_min", digits_b, 24'h010000);
    wait_cycles(353999);
    check("b_max_digits",   digits_b, 24'h595999);
    check("b_max_rollover", {23'd0, rollover_b}, 24'd0);
    wait_cycles(1);
    check("b_wrap_digits",   digits_b, 24'h000000);
    check("b_wrap_rollover", {23'd0, rollover_b}, 24'd1);
    check("b_wrap_running",  {23'd0, running_b},  24'd1);
    wait_cycles(1);
    check("b_post_digits",   digits_b, 24'h000001);
    check("b_post_rollover", {23'd0, rollover_b}, 24'd0);
    check("b_lap_hold",      {23'd0, lap_hold_b}, 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
